// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the reverse-Polish sequencer.
//   opcode_e  - operator encodings carried in tok_dat[2:0]
//   state_e   - sequencer FSM states
//   ERR_*     - err_code values
package rpn_pkg;

   localparam int unsigned OPC_W = 3;
   localparam int unsigned ERR_W = 2;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP_A,
      S_POP_B,
      S_PUSH_R,
      S_ERR
   } state_e;

   localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
   localparam logic [ERR_W-1:0] ERR_OVF  = 2'b01;
   localparam logic [ERR_W-1:0] ERR_UNF  = 2'b10;
   localparam logic [ERR_W-1:0] ERR_ILL  = 2'b11;

endpackage

// File: rtl/rpn_sequencer_if.sv
// rpn_sequencer_if: token stream into the sequencer (valid/ready handshake).
//   tok_valid - token offered (source)
//   tok_ready - token accepted when tok_valid & tok_ready (sink)
//   tok_is_op - 1 operator, 0 operand (source)
//   tok_dat   - operand value or opcode in [2:0] (source)
// Modports: master = token source, slave = sequencer.
interface rpn_sequencer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             tok_valid;
   logic             tok_ready;
   logic             tok_is_op;
   logic [WIDTH-1:0] tok_dat;

   modport master (
      output tok_valid,
      output tok_is_op,
      output tok_dat,
      input  tok_ready
   );

   modport slave (
      input  tok_valid,
      input  tok_is_op,
      input  tok_dat,
      output tok_ready
   );
endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational operator unit, result = b OP a modulo 2^WIDTH.
//   op      - opcode (tok_dat[2:0] encoding)
//   a, b    - a = former top of stack, b = second entry
//   result  - WIDTH-bit result, carries / high product bits dropped
//   illegal - opcode not supported by this build
// Build option: RPN_MUL_EN adds MUL (opcode 101); without it 101 is illegal
// and no multiplier exists.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [OPC_W-1:0] op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             illegal
);

   // Operator decode; anything not listed is flagged illegal.
   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (op)
         OP_ADD:  result = b + a;
         OP_SUB:  result = b - a;
         OP_AND:  result = b & a;
         OP_OR:   result = b | a;
         OP_XOR:  result = b ^ a;
`ifdef RPN_MUL_EN
         OP_MUL:  result = WIDTH'(b * a);
`else
`endif
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: token-driven RPN evaluator sitting in front of a stack block.
//   clk, rst     - clock (rising), asynchronous active-high reset shared with the stack
//   tok          - token stream (rpn_sequencer_if.slave)
//   stk_push_stb / stk_push_dat / stk_pop_stb - stack controls
//   stk_pop_dat  - stack top-of-stack, combinational
//   top_dat      - stk_pop_dat when depth>0, else 0
//   depth        - occupancy tracked locally
//   busy         - operator in progress
//   err/err_code - error flag (held while in ERR) and cause
//   err_clr      - leaves ERR; ignored elsewhere
// Build option: RPN_MUL_EN enables opcode 101 (MUL) inside rpn_alu.
module rpn_sequencer
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 100
) (
   input  logic                         clk,
   input  logic                         rst,
   rpn_sequencer_if.slave               tok,
   output logic                         stk_push_stb,
   output logic [WIDTH-1:0]             stk_push_dat,
   output logic                         stk_pop_stb,
   input  logic [WIDTH-1:0]             stk_pop_dat,
   output logic [WIDTH-1:0]             top_dat,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         busy,
   output logic                         err,
   output logic [ERR_W-1:0]             err_code,
   input  logic                         err_clr
);

   localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   state_e             state_q, state_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [ERR_W-1:0]   err_code_q, err_code_d;
   logic [OPC_W-1:0]   op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;

   logic [OPC_W-1:0]   alu_op;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_illegal;

   // One ALU serves both jobs: legality of the offered opcode in IDLE,
   // and the result of the latched opcode in PUSH_R.
   assign alu_op = (state_q == S_IDLE) ? tok.tok_dat[OPC_W-1:0] : op_q;

   rpn_alu #(.WIDTH(WIDTH)) u_alu (
      .op      (alu_op),
      .a       (a_q),
      .b       (b_q),
      .result  (alu_result),
      .illegal (alu_illegal)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         depth_q    <= '0;
         err_code_q <= ERR_NONE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
      end else begin
         state_q    <= state_d;
         depth_q    <= depth_d;
         err_code_q <= err_code_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
      end
   end

   // Next-state and stack strobes; operand pushes happen in the accept cycle.
   always_comb begin
      state_d      = state_q;
      depth_d      = depth_q;
      err_code_d   = err_code_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      stk_push_stb = 1'b0;
      stk_push_dat = '0;
      stk_pop_stb  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tok.tok_valid) begin
               if (!tok.tok_is_op) begin
                  if (depth_q < DEPTH_MAX) begin
                     stk_push_stb = 1'b1;
                     stk_push_dat = tok.tok_dat;
                     depth_d      = depth_q + DEPTH_ONE;
                  end else begin
                     err_code_d = ERR_OVF;
                     state_d    = S_ERR;
                  end
               end else if (alu_illegal) begin
                  err_code_d = ERR_ILL;
                  state_d    = S_ERR;
               end else if (depth_q < DEPTH_TWO) begin
                  err_code_d = ERR_UNF;
                  state_d    = S_ERR;
               end else begin
                  op_d    = tok.tok_dat[OPC_W-1:0];
                  state_d = S_POP_A;
               end
            end
         end
         S_POP_A: begin
            a_d         = stk_pop_dat;
            stk_pop_stb = 1'b1;
            depth_d     = depth_q - DEPTH_ONE;
            state_d     = S_POP_B;
         end
         S_POP_B: begin
            b_d         = stk_pop_dat;
            stk_pop_stb = 1'b1;
            depth_d     = depth_q - DEPTH_ONE;
            state_d     = S_PUSH_R;
         end
         S_PUSH_R: begin
            stk_push_stb = 1'b1;
            stk_push_dat = alu_result;
            depth_d      = depth_q + DEPTH_ONE;
            state_d      = S_IDLE;
         end
         S_ERR: begin
            if (err_clr) begin
               err_code_d = ERR_NONE;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tok.tok_ready = (state_q == S_IDLE);
   assign busy          = (state_q == S_POP_A) || (state_q == S_POP_B) || (state_q == S_PUSH_R);
   assign err           = (state_q == S_ERR);
   assign err_code      = err_code_q;
   assign depth         = depth_q;
   assign top_dat       = (depth_q != '0) ? stk_pop_dat : '0;

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: directed + randomized token streams against a token-level
// RPN model (a queue evaluated with plain arithmetic). A behavioural stack
// answers the sequencer's strobes; its contents are compared to the model.
module tb_rpn_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = $clog2(DEPTH + 1);

   localparam int K_PUSH = 0;
   localparam int K_OP   = 1;
   localparam int K_ERR  = 2;

`ifdef RPN_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             stk_push_stb;
   logic [WIDTH-1:0] stk_push_dat;
   logic             stk_pop_stb;
   logic [WIDTH-1:0] stk_top;
   logic [WIDTH-1:0] top_dat;
   logic [DW-1:0]    depth;
   logic             busy;
   logic             err;
   logic [1:0]       err_code;
   logic             err_clr;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] stk_q[$];

   rpn_sequencer_if #(.WIDTH(WIDTH)) tok_if ();

   rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .tok          (tok_if.slave),
      .stk_push_stb (stk_push_stb),
      .stk_push_dat (stk_push_dat),
      .stk_pop_stb  (stk_pop_stb),
      .stk_pop_dat  (stk_top),
      .top_dat      (top_dat),
      .depth        (depth),
      .busy         (busy),
      .err          (err),
      .err_code     (err_code),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   // Behavioural stack sharing rst; top published with NBA so the DUT
   // samples the pre-edge top.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stk_q.delete();
         stk_top <= '0;
      end else begin
         if (stk_pop_stb && stk_q.size() > 0) void'(stk_q.pop_back());
         if (stk_push_stb) stk_q.push_back(stk_push_dat);
         stk_top <= (stk_q.size() > 0) ? stk_q[$] : '0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Token-level reference: evaluates one token on the model stack.
   task automatic model_step(input bit is_op, input logic [WIDTH-1:0] dat,
                             output int kind, output logic [1:0] code,
                             output logic [WIDTH-1:0] res);
      int ia, ib, r, opc;
      kind = K_PUSH; code = 2'b00; res = '0;
      if (!is_op) begin
         if (model_q.size() < DEPTH) model_q.push_back(dat);
         else begin kind = K_ERR; code = 2'b01; end
      end else begin
         opc = int'(dat) % 8;
         if (opc > 5 || (opc == 5 && !MUL_EN)) begin
            kind = K_ERR; code = 2'b11;
         end else if (model_q.size() < 2) begin
            kind = K_ERR; code = 2'b10;
         end else begin
            ia = int'(model_q.pop_back());
            ib = int'(model_q.pop_back());
            case (opc)
               0: r = ib + ia;
               1: r = ib - ia;
               2: r = ib & ia;
               3: r = ib | ia;
               4: r = ib ^ ia;
               default: r = ib * ia;
            endcase
            res = r[WIDTH-1:0];
            model_q.push_back(res);
            kind = K_OP;
         end
      end
   endtask

   task automatic check_state(input string tag);
      int mm = 0;
      check({tag, "_depth"}, depth, model_q.size());
      check({tag, "_top"}, top_dat, (model_q.size() > 0) ? model_q[$] : 0);
      if (stk_q.size() != model_q.size()) mm++;
      else foreach (stk_q[i]) if (stk_q[i] !== model_q[i]) mm++;
      check({tag, "_stack"}, mm, 0);
   endtask

   // Offer one token (DUT must be idle), then follow it to completion.
   task automatic run_token(input bit is_op, input logic [WIDTH-1:0] dat, input bit clr_noise);
      int kind;
      logic [1:0] code;
      logic [WIDTH-1:0] res;
      int hold;
      model_step(is_op, dat, kind, code, res);
      check("ready_idle", tok_if.tok_ready, 1);
      tok_if.tok_valid = 1'b1;
      tok_if.tok_is_op = is_op;
      tok_if.tok_dat   = dat;
      err_clr          = clr_noise;
      #1;
      check("accept_push_stb", stk_push_stb, kind == K_PUSH);
      if (kind == K_PUSH) check("accept_push_dat", stk_push_dat, dat);
      check("accept_pop_stb", stk_pop_stb, 0);
      @(posedge clk); #1;
      tok_if.tok_valid = 1'b0;
      err_clr          = 1'b0;
      if (kind == K_OP) begin
         for (int c = 1; c <= 3; c++) begin
            check("op_busy", busy, 1);
            check("op_ready", tok_if.tok_ready, 0);
            check("op_pop_stb", stk_pop_stb, c < 3);
            check("op_push_stb", stk_push_stb, c == 3);
            if (c == 3) check("op_result", stk_push_dat, res);
            @(posedge clk); #1;
         end
         check("op_done_busy", busy, 0);
      end else if (kind == K_ERR) begin
         check("err_flag", err, 1);
         check("err_code", err_code, code);
         hold = $urandom_range(0, 2);
         for (int c = 0; c <= hold; c++) begin
            check("err_ready", tok_if.tok_ready, 0);
            check("err_strobes", {stk_push_stb, stk_pop_stb}, 0);
            tok_if.tok_valid = $urandom_range(0, 1);
            tok_if.tok_is_op = $urandom_range(0, 1);
            tok_if.tok_dat   = WIDTH'($urandom);
            @(posedge clk); #1;
         end
         check("err_hold_depth", depth, model_q.size());
         tok_if.tok_valid = 1'b0;
         err_clr = 1'b1;
         @(posedge clk); #1;
         err_clr = 1'b0;
         check("err_cleared", {err, err_code}, 0);
      end
      check_state("post");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tok_if.tok_valid = 1'b0;
      tok_if.tok_is_op = 1'b0;
      tok_if.tok_dat   = '0;
      err_clr          = 1'b0;
      model_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_depth", depth, 0);
      check("rst_err", {err, err_code}, 0);
      check("rst_strobes", {stk_push_stb, stk_pop_stb}, 0);
      check("rst_ready", tok_if.tok_ready, 1);
      check("rst_top", top_dat, 0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      do_reset();

      // 3 + 5
      run_token(0, 4'd3, 0);
      run_token(0, 4'd5, 0);
      run_token(1, 4'd0, 0);
      check("t1_top", top_dat, 4'd8);

      // 2 - 7 wraps to B; 9 + 9 wraps to 2
      do_reset();
      run_token(0, 4'd2, 0);
      run_token(0, 4'd7, 0);
      run_token(1, 4'd1, 0);
      check("t2_sub", top_dat, 4'hB);
      run_token(0, 4'd9, 0);
      run_token(0, 4'd9, 0);
      run_token(1, 4'd0, 0);
      check("t2_add", top_dat, 4'h2);

      // underflow, then clear keeps contents
      do_reset();
      run_token(0, 4'd1, 0);
      run_token(1, 4'd0, 1);
      check("t3_top", top_dat, 4'd1);

      // overflow at DEPTH
      do_reset();
      for (int i = 1; i <= 5; i++) run_token(0, WIDTH'(i), 0);
      check("t4_depth", depth, 4);
      check("t4_top", top_dat, 4'd4);

      // opcode 101, and an always-illegal opcode
      do_reset();
      run_token(0, 4'd3, 0);
      run_token(0, 4'd6, 0);
      run_token(1, 4'd5, 0);
      check("t5_top", top_dat, MUL_EN ? 4'h2 : 4'h6);
      run_token(1, 4'd7, 0);

      // reset while in POP_B
      do_reset();
      run_token(0, 4'd3, 0);
      run_token(0, 4'd5, 0);
      tok_if.tok_valid = 1'b1;
      tok_if.tok_is_op = 1'b1;
      tok_if.tok_dat   = 4'd0;
      @(posedge clk); #1;
      tok_if.tok_valid = 1'b0;
      check("t6_busy_pop_a", busy, 1);
      @(posedge clk); #1;
      check("t6_pop_b_stb", stk_pop_stb, 1);
      rst = 1'b1;
      model_q.delete();
      #1;
      check("t6_depth", depth, 0);
      check("t6_strobes", {stk_push_stb, stk_pop_stb, busy}, 0);
      check("t6_ready", tok_if.tok_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_token(0, 4'd6, 0);

      // randomized token stream
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) < 4)
            run_token(1, WIDTH'($urandom), $urandom_range(0, 7) == 0);
         else
            run_token(0, WIDTH'($urandom), $urandom_range(0, 7) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
